// File: rtl/row_col_cod_nxn.sv
// Row/column coder for a SIZE x SIZE DCO capacitor array with optional slew limiting.
// Maps the applied tuning value onto full rows (active low), a one-hot partial row and a column thermometer.
module row_col_cod_nxn #(
    parameter int SIZE = 5,
    parameter int MAX  = SIZE * SIZE,
    parameter int W    = $clog2(MAX + 1),
    parameter int STEP = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            snake,
    input  logic [W-1:0]    word,
    output logic [SIZE-1:0] r_all,
    output logic [SIZE-1:0] row,
    output logic [SIZE-1:0] col,
    output logic            settled,
    output logic            err
);
    localparam logic [W-1:0] MAX_V    = W'(MAX);
    localparam int           STEP_SAT = (STEP > MAX) ? MAX : STEP;
    localparam logic [W:0]   STEP_V   = (W+1)'(STEP_SAT);

    logic [W-1:0]    cur_reg, tgt_reg;
    logic [SIZE-1:0] r_all_reg, row_reg, col_reg;
    logic            settled_reg, err_reg;

    logic            word_ok;
    logic [W-1:0]    tgt_next, cur_next, cb_next;
    logic [W:0]      diff, mag;
    logic [31:0]     v_int;
    logic            rb_odd;
    logic [SIZE-1:0] r_all_next, row_next, col_lin, col_snk, col_next;

    // Target capture and bounded step; the |d| <= STEP check guarantees no overshoot
    always_comb begin
        word_ok  = (word <= MAX_V);
        tgt_next = word_ok ? word : tgt_reg;
        diff     = {1'b0, tgt_next} - {1'b0, cur_reg};
        mag      = diff[W] ? (~diff + 1'b1) : diff;
        if (STEP == 0 || mag <= STEP_V)
            cur_next = tgt_next;
        else if (!diff[W])
            cur_next = cur_reg + STEP_V[W-1:0];
        else
            cur_next = cur_reg - STEP_V[W-1:0];
    end

    assign v_int = 32'(cur_next);

    // Partial-row base found by a compare chain; v = k*SIZE stays on row k-1 with a full col
    always_comb begin
        logic [31:0] base;
        base   = '0;
        rb_odd = 1'b0;
        for (int k = 1; k < SIZE; k++) begin
            if (v_int > 32'(k * SIZE)) begin
                base   = 32'(k * SIZE);
                rb_odd = k[0];
            end
        end
        cb_next = W'(v_int - base);
    end

    for (genvar gi = 0; gi < SIZE; gi++) begin : g_cell
        assign r_all_next[gi] = !(v_int > 32'((gi + 1) * SIZE));
        assign row_next[gi]   = ((gi == 0) || (v_int > 32'(gi * SIZE))) &&
                                !(v_int > 32'((gi + 1) * SIZE));
        assign col_lin[gi]    = (32'(cb_next) > 32'(gi));
        assign col_snk[gi]    = (32'(cb_next) >= 32'(SIZE - gi));
    end

    assign col_next = (snake && rb_odd) ? col_snk : col_lin;

    always_ff @(negedge clk) begin
        if (rst) begin
            cur_reg     <= '0;
            tgt_reg     <= '0;
            r_all_reg   <= '0;
            row_reg     <= '0;
            col_reg     <= '0;
            settled_reg <= 1'b1;
            err_reg     <= 1'b0;
        end else if (en) begin
            cur_reg     <= cur_next;
            tgt_reg     <= tgt_next;
            r_all_reg   <= r_all_next;
            row_reg     <= row_next;
            col_reg     <= col_next;
            settled_reg <= (cur_next == tgt_next);
            err_reg     <= !word_ok;
        end
    end

    assign r_all   = r_all_reg;
    assign row     = row_reg;
    assign col     = col_reg;
    assign settled = settled_reg;
    assign err     = err_reg;
endmodule
